// File: rtl/semaphore_ctrl.sv
// rtl/semaphore_ctrl.sv - two-approach traffic light sequencer with pedestrian shortening and flash mode
module semaphore_ctrl #(
   parameter int GREEN_TICKS      = 8,
   parameter int MIN_GREEN_TICKS  = 3,
   parameter int YELLOW_TICKS     = 2,
   parameter int ALLRED_TICKS     = 1,
   parameter int FLASH_HALF_TICKS = 1,
   parameter int CNT_W            = 8
) (
   input  logic       clk,
   input  logic       res,
   input  logic       tick,
   input  logic       dis,
   input  logic       ped_req,
   output logic       r,
   output logic       g,
   output logic       v,
   output logic       r1,
   output logic       g1,
   output logic       v1,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      ALLRED_A = 3'd0,
      A_GREEN  = 3'd1,
      A_YELLOW = 3'd2,
      ALLRED_B = 3'd3,
      B_GREEN  = 3'd4,
      B_YELLOW = 3'd5,
      FLASH    = 3'd6,
      ILLEGAL  = 3'd7
   } state_t;

   // Last count value of each phase; a phase of N ticks ends when cnt reaches N-1.
   localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_HALF_TICKS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             ped_pend;
   logic             flash_ph;
   logic             green_done;
   logic             green_to_yellow;
   logic             flash_toggle;

   // Green may end at full length, or early once a pedestrian is waiting and minimum green is served.
   assign green_done      = (cnt == GREEN_LAST) || (ped_pend && (cnt >= MIN_LAST));
   assign green_to_yellow = ((state == A_GREEN) && (state_nxt == A_YELLOW)) ||
                            ((state == B_GREEN) && (state_nxt == B_YELLOW));
   assign flash_toggle    = (state == FLASH) && tick && (cnt == FLASH_LAST);
   assign phase           = state;

   // Next-state selection and lamp decode; dis overrides any tick-driven exit.
   always_comb begin
      state_nxt = state;
      r  = 1'b0;
      g  = 1'b0;
      v  = 1'b0;
      r1 = 1'b0;
      g1 = 1'b0;
      v1 = 1'b0;
      case (state)
         ALLRED_A: begin
            r  = 1'b1;
            r1 = 1'b1;
            if (tick && (cnt == ALLRED_LAST)) state_nxt = A_GREEN;
         end
         A_GREEN: begin
            v  = 1'b1;
            r1 = 1'b1;
            if (tick && green_done) state_nxt = A_YELLOW;
         end
         A_YELLOW: begin
            g  = 1'b1;
            r1 = 1'b1;
            if (tick && (cnt == YELLOW_LAST)) state_nxt = ALLRED_B;
         end
         ALLRED_B: begin
            r  = 1'b1;
            r1 = 1'b1;
            if (tick && (cnt == ALLRED_LAST)) state_nxt = B_GREEN;
         end
         B_GREEN: begin
            r  = 1'b1;
            v1 = 1'b1;
            if (tick && green_done) state_nxt = B_YELLOW;
         end
         B_YELLOW: begin
            r  = 1'b1;
            g1 = 1'b1;
            if (tick && (cnt == YELLOW_LAST)) state_nxt = ALLRED_A;
         end
         FLASH: begin
            g  = flash_ph;
            g1 = flash_ph;
            if (!dis) state_nxt = ALLRED_A;
         end
         default: state_nxt = ALLRED_A;
      endcase
      if (dis && (state != FLASH) && (state != ILLEGAL)) state_nxt = FLASH;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (res) state <= ALLRED_A;
      else     state <= state_nxt;
   end

   // Phase counter: cleared on entry, advances on tick, wraps each half-period in flash.
   always_ff @(posedge clk) begin
      if (res)                     cnt <= '0;
      else if (state_nxt != state) cnt <= '0;
      else if (flash_toggle)       cnt <= '0;
      else if (tick)               cnt <= cnt + 1'b1;
   end

   // Pedestrian latch: a new request outranks the clear at the green exit.
   always_ff @(posedge clk) begin
      if (res)                  ped_pend <= 1'b0;
      else if (state == FLASH)  ped_pend <= 1'b0;
      else if (ped_req)         ped_pend <= 1'b1;
      else if (green_to_yellow) ped_pend <= 1'b0;
   end

   // Flash phase: lit on entry, toggles each half-period, parked low outside flash.
   always_ff @(posedge clk) begin
      if (res)                                          flash_ph <= 1'b0;
      else if ((state_nxt == FLASH) && (state != FLASH)) flash_ph <= 1'b1;
      else if (state_nxt != FLASH)                      flash_ph <= 1'b0;
      else if (flash_toggle)                            flash_ph <= ~flash_ph;
   end

endmodule

// File: tb/tb_semaphore_ctrl.sv
// tb/tb_semaphore_ctrl.sv - directed and random bench for semaphore_ctrl
module tb_semaphore_ctrl;

   logic       clk = 1'b0;
   logic       res = 1'b0;
   logic       tick = 1'b0;
   logic       dis = 1'b0;
   logic       ped_req = 1'b0;
   logic       r, g, v, r1, g1, v1;
   logic [2:0] phase;
   logic [5:0] lamps;

   int n_assert = 0;
   int n_fail   = 0;

   semaphore_ctrl dut (
      .clk(clk), .res(res), .tick(tick), .dis(dis), .ped_req(ped_req),
      .r(r), .g(g), .v(v), .r1(r1), .g1(g1), .v1(v1), .phase(phase)
   );

   always #5 clk = ~clk;

   assign lamps = {r, g, v, r1, g1, v1};

   // Lamp table {r,g,v,r1,g1,v1} per phase code.
   function automatic logic [5:0] exp_lamps(input logic [2:0] ph, input logic fph);
      case (ph)
         3'd0:    return 6'b100100;
         3'd1:    return 6'b001100;
         3'd2:    return 6'b010100;
         3'd3:    return 6'b100100;
         3'd4:    return 6'b100001;
         3'd5:    return 6'b100010;
         3'd6:    return {1'b0, fph, 1'b0, 1'b0, fph, 1'b0};
         default: return 6'b000000;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      res = 1'b1; tick = 1'b0; dis = 1'b0; ped_req = 1'b0;
      step();
      res = 1'b0;
   endtask

   task automatic wait_phase(input logic [2:0] ph, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (phase == ph) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic run_phase(input logic [2:0] ph, output int n);
      n = 0;
      while (phase == ph && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      tick = 1'b1; dis = 1'b0;
      repeat (5) step();
      do_reset();
      n_assert++;
      if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
      n_assert++;
      if (lamps !== 6'b100100) begin n_fail++; $display("FAIL reset_lamps: got %b expected 100100", lamps); end
      n_assert++;
      if (dut.cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
      n_assert++;
      if (dut.ped_pend !== 1'b0) begin n_fail++; $display("FAIL reset_ped_pend: got %0d expected 0", dut.ped_pend); end
   endtask

   task automatic test_normal_cycle();
      int dur[6] = '{1, 8, 2, 1, 8, 2};
      int eph = 0;
      int ecnt = 0;
      do_reset();
      tick = 1'b1;
      for (int c = 0; c < 44; c++) begin
         step();
         if (ecnt == dur[eph] - 1) begin
            eph  = (eph + 1) % 6;
            ecnt = 0;
         end else begin
            ecnt++;
         end
         n_assert++;
         if (phase !== 3'(eph)) begin n_fail++; $display("FAIL cycle_phase[%0d]: got %0d expected %0d", c, phase, eph); end
         n_assert++;
         if (lamps !== exp_lamps(3'(eph), 1'b0)) begin n_fail++; $display("FAIL cycle_lamps[%0d]: got %b expected %b", c, lamps, exp_lamps(3'(eph), 1'b0)); end
         n_assert++;
         if (dut.cnt !== 8'(ecnt)) begin n_fail++; $display("FAIL cycle_cnt[%0d]: got %0d expected %0d", c, dut.cnt, ecnt); end
      end
   endtask

   task automatic test_ped_pulse();
      int n;
      bit ok;
      do_reset();
      tick = 1'b1;
      step();
      ped_req = 1'b1;
      step();
      ped_req = 1'b0;
      n_assert++;
      if (dut.ped_pend !== 1'b1) begin n_fail++; $display("FAIL ped_pulse_latch: got %0d expected 1", dut.ped_pend); end
      run_phase(3'd1, n);
      n_assert++;
      if (n + 1 != 3) begin n_fail++; $display("FAIL ped_pulse_a_green_len: got %0d expected 3", n + 1); end
      n_assert++;
      if (phase !== 3'd2) begin n_fail++; $display("FAIL ped_pulse_exit_phase: got %0d expected 2", phase); end
      n_assert++;
      if (dut.ped_pend !== 1'b0) begin n_fail++; $display("FAIL ped_pulse_clear: got %0d expected 0", dut.ped_pend); end
      wait_phase(3'd4, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL ped_pulse_reach_b: got timeout expected phase 4"); end
      run_phase(3'd4, n);
      n_assert++;
      if (n != 8) begin n_fail++; $display("FAIL ped_pulse_b_green_len: got %0d expected 8", n); end
   endtask

   task automatic test_ped_hold();
      int n;
      bit ok;
      do_reset();
      tick = 1'b1;
      step();
      ped_req = 1'b1;
      run_phase(3'd1, n);
      n_assert++;
      if (n != 3) begin n_fail++; $display("FAIL ped_hold_a_green_len: got %0d expected 3", n); end
      n_assert++;
      if (dut.ped_pend !== 1'b1) begin n_fail++; $display("FAIL ped_hold_set_wins: got %0d expected 1", dut.ped_pend); end
      ped_req = 1'b0;
      wait_phase(3'd4, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL ped_hold_reach_b: got timeout expected phase 4"); end
      run_phase(3'd4, n);
      n_assert++;
      if (n != 3) begin n_fail++; $display("FAIL ped_hold_b_green_len: got %0d expected 3", n); end
   endtask

   task automatic test_flash();
      bit ok;
      logic exp_g;
      do_reset();
      tick = 1'b1;
      wait_phase(3'd4, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL flash_reach_b: got timeout expected phase 4"); end
      repeat (4) step();
      n_assert++;
      if (dut.cnt !== 8'd4) begin n_fail++; $display("FAIL flash_pre_cnt: got %0d expected 4", dut.cnt); end
      dis = 1'b1;
      exp_g = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_assert++;
         if (phase !== 3'd6) begin n_fail++; $display("FAIL flash_phase[%0d]: got %0d expected 6", k, phase); end
         n_assert++;
         if (lamps !== {1'b0, exp_g, 1'b0, 1'b0, exp_g, 1'b0}) begin
            n_fail++; $display("FAIL flash_lamps[%0d]: got %b expected %b", k, lamps, {1'b0, exp_g, 1'b0, 1'b0, exp_g, 1'b0});
         end
         exp_g = ~exp_g;
      end
      dis = 1'b0;
      step();
      n_assert++;
      if (phase !== 3'd0) begin n_fail++; $display("FAIL flash_exit_phase: got %0d expected 0", phase); end
      n_assert++;
      if (lamps !== 6'b100100) begin n_fail++; $display("FAIL flash_exit_lamps: got %b expected 100100", lamps); end
      step();
      n_assert++;
      if (phase !== 3'd1) begin n_fail++; $display("FAIL flash_then_green: got %0d expected 1", phase); end
   endtask

   task automatic test_res_in_flash();
      tick = 1'b1;
      dis = 1'b1;
      step();
      step();
      n_assert++;
      if (phase !== 3'd6) begin n_fail++; $display("FAIL res_flash_pre: got %0d expected 6", phase); end
      res = 1'b1;
      step();
      res = 1'b0;
      n_assert++;
      if (phase !== 3'd0) begin n_fail++; $display("FAIL res_flash_phase: got %0d expected 0", phase); end
      n_assert++;
      if (lamps !== 6'b100100) begin n_fail++; $display("FAIL res_flash_lamps: got %b expected 100100", lamps); end
      step();
      n_assert++;
      if (phase !== 3'd6) begin n_fail++; $display("FAIL res_flash_reenter: got %0d expected 6", phase); end
      dis = 1'b0;
      step();
   endtask

   task automatic test_tick_hold();
      bit ok;
      do_reset();
      tick = 1'b1;
      wait_phase(3'd2, ok);
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL hold_reach_yellow: got timeout expected phase 2"); end
      step();
      tick = 1'b0;
      for (int k = 0; k < 50; k++) begin
         step();
         n_assert++;
         if (phase !== 3'd2 || lamps !== 6'b010100) begin
            n_fail++; $display("FAIL hold_frozen[%0d]: got phase %0d lamps %b expected phase 2 lamps 010100", k, phase, lamps);
         end
      end
      tick = 1'b1;
      step();
      n_assert++;
      if (phase !== 3'd3) begin n_fail++; $display("FAIL hold_resume: got %0d expected 3", phase); end
   endtask

   task automatic test_random_safety();
      logic       pdis;
      logic [2:0] pph;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         tick    = ($urandom_range(0, 1) == 1);
         ped_req = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 29) == 0) dis = ~dis;
         pdis = dis;
         pph  = phase;
         step();
         n_assert++;
         if (phase != 3'd6 && (v | g) && (v1 | g1)) begin
            n_fail++; $display("FAIL safety[%0d]: got lamps %b in phase %0d expected one approach red", c, lamps, phase);
         end
         n_assert++;
         if (phase == 3'd7) begin n_fail++; $display("FAIL illegal_phase[%0d]: got 7 expected 0..6", c); end
         if (pdis) begin
            n_assert++;
            if (phase !== 3'd6) begin n_fail++; $display("FAIL dis_latency[%0d]: got %0d expected 6", c, phase); end
         end else if (pph == 3'd6) begin
            n_assert++;
            if (phase !== 3'd0) begin n_fail++; $display("FAIL undis_latency[%0d]: got %0d expected 0", c, phase); end
         end
      end
      dis = 1'b0; tick = 1'b0; ped_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_normal_cycle();
      test_ped_pulse();
      test_ped_hold();
      test_flash();
      test_res_in_flash();
      test_tick_hold();
      test_random_safety();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/semaphore_ctrl.md
# semaphore_ctrl

Two-way traffic-light sequencer driving one red/yellow/green lamp set per approach (A and B). It replaces the decade-counter-plus-latch arrangement with a tick-driven Moore FSM. Phase durations are programmable, a pedestrian request shortens the current green, and a maintenance input switches both approaches to flashing yellow. Outputs connect directly to the lamp drivers; `tick` comes from a shared prescaler.

## Interface
- `GREEN_TICKS`, 8: full green duration, in ticks (1..2^CNT_W-1)
- `MIN_GREEN_TICKS`, 3: minimum green once a pedestrian request is pending (1..GREEN_TICKS)
- `YELLOW_TICKS`, 2: yellow duration
- `ALLRED_TICKS`, 1: all-red clearance before each green
- `FLASH_HALF_TICKS`, 1: yellow on-time, and also off-time, in flash mode
- `CNT_W`, 8: phase counter width

Ports:
- `clk`  in  1  clock
- `res`  in  1  reset, synchronous, active-high
- `tick`  in  1  timing enable, single-cycle pulse; the FSM advances only on cycles where tick=1
- `dis`  in  1  maintenance/flash request, level
- `ped_req`  in  1  pedestrian button, level or pulse
- `r`, `g`, `v`  out  1 each  approach A red, yellow, green
- `r1`, `g1`, `v1`  out  1 each  approach B red, yellow, green
- `phase`  out  3  current state code

## Operation
- State codes: ALLRED_A=0, A_GREEN=1, A_YELLOW=2, ALLRED_B=3, B_GREEN=4, B_YELLOW=5, FLASH=6. Code 7 is illegal and recovers to ALLRED_A on the next edge.
- Normal cycle: ALLRED_A → A_GREEN → A_YELLOW → ALLRED_B → B_GREEN → B_YELLOW → ALLRED_A.
- Phase counter `cnt` (CNT_W bits):
  - Cleared on every state entry.
  - Increments on tick.
  - A phase of duration N ends on the tick where cnt==N-1, so each phase lasts exactly N ticks.
- Green exit: on the tick where cnt==GREEN_TICKS-1, or on the tick where ped_pend=1 and cnt>=MIN_GREEN_TICKS-1.
- `ped_pend` register:
  - Set on any cycle where ped_req=1 and the state is not FLASH.
  - Cleared on the green→yellow transition edge. If ped_req=1 in that same cycle, set wins.
  - Cleared in FLASH and on res.
  - Exit decisions use the registered ped_pend, never ped_req directly.
- Lamp decode from state:
  - A: v=1 in A_GREEN; g=1 in A_YELLOW; r=1 in ALLRED_A, ALLRED_B, B_GREEN, B_YELLOW.
  - B is symmetric: v1=1 in B_GREEN; g1=1 in B_YELLOW; r1=1 in the other four non-flash states.
- FLASH:
  - r, v, r1, v1 are all 0. g=g1=flash_ph.
  - flash_ph is 1 on entry and toggles on the tick where cnt==FLASH_HALF_TICKS-1; cnt then clears.
- dis handling:
  - dis=1 in any non-FLASH state → FLASH on the next edge, regardless of tick or cnt.
  - dis=0 in FLASH → ALLRED_A on the next edge, with cnt=0.
- Safety invariant: at most one of {v, g} ∪ {v1, g1} groups is active outside FLASH. A is never non-red while B is non-red.

## Timing
- res has priority over everything else. After a res edge: phase=0, cnt=0, ped_pend=0, flash_ph=0, r=1, r1=1, and all other lamps 0.
- Lamps and phase are a decode of registered state. They change on the same edge as the state transition, with no extra latency.
- Latencies:
  - dis rise → FLASH visible 1 cycle later.
  - dis fall → ALLRED_A 1 cycle later.
  - ped_req → ped_pend 1 cycle later.
- tick=0: state, cnt and flash_ph hold. dis and res still act on the next edge.
- Simultaneous tick exit and dis=1 in the same cycle: FLASH wins.
- cnt never exceeds max(parameter)-1. No wrap occurs in legal configurations.

## Test plan
- Reset, then tick=1 every cycle, defaults:
  - Phases are 0(1) 1(8) 2(2) 3(1) 4(8) 5(2) ticks, giving a 22-cycle period.
  - Lamp decode is checked every cycle.
- ped_req pulse 1 cycle after A_GREEN entry, tick=1 every cycle:
  - A_GREEN lasts 3 ticks.
  - ped_pend clears on the exit edge.
  - The following B_GREEN lasts the full 8 ticks.
- ped_req held high across the A_GREEN→A_YELLOW edge:
  - ped_pend stays 1.
  - B_GREEN is shortened to 3 ticks.
- dis raised at B_GREEN cnt=4:
  - phase=6 next cycle.
  - g=g1 run 1,0,1,0 every tick, with r, v, r1, v1 = 0.
  - dis drops → phase=0 one cycle later, then A_GREEN after 1 tick.
- res pulsed mid-FLASH with dis=1:
  - On the res cycle, phase=0, r=r1=1.
  - On the next cycle, phase=6.
- tick=0 for 50 cycles during A_YELLOW:
  - phase and lamps unchanged.
  - Resumes with the remaining yellow tick.
- Safety check over a long random run of tick, dis and ped_req: outside FLASH, (v|g) and (v1|g1) are never both 1.
